// File: rtl/timed_phase_sequencer_if.sv
// Control, configuration and status bundle for timed_phase_sequencer.
// master drives control and config; slave is the sequencer and drives status.
interface timed_phase_sequencer_if #(
    parameter int NUM_STATES = 4,
    parameter int OUT_W      = 4,
    parameter int CNT_W      = 4
);
    localparam int IDX_W = $clog2(NUM_STATES);

    logic             start;
    logic             stop;
    logic             loop_en;
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [CNT_W-1:0] cfg_dwell;
    logic [OUT_W-1:0] cfg_value;
    logic [OUT_W-1:0] y;
    logic [IDX_W-1:0] state;
    logic             busy;
    logic [CNT_W-1:0] dwell_cnt;
    logic             step;
    logic             done;

    modport master (
        output start, stop, loop_en, cfg_we, cfg_idx, cfg_dwell, cfg_value,
        input  y, state, busy, dwell_cnt, step, done
    );

    modport slave (
        input  start, stop, loop_en, cfg_we, cfg_idx, cfg_dwell, cfg_value,
        output y, state, busy, dwell_cnt, step, done
    );
endinterface

// File: rtl/timed_phase_sequencer.sv
// Timed phase sequencer: walks NUM_STATES phases, each held for a programmable dwell and driving a code on y.
// All outputs registered, one cycle after the deciding edge; no backpressure, start ignored while busy.
module timed_phase_sequencer #(
    parameter int                 NUM_STATES = 4,
    parameter int                 OUT_W      = 4,
    parameter int                 CNT_W      = 4,
    parameter logic [OUT_W-1:0]   IDLE_VALUE = '0,
    parameter logic [CNT_W-1:0]   DEF_DWELL  = CNT_W'(1)
) (
    input  logic                   clk,
    input  logic                   rst,
    timed_phase_sequencer_if.slave sq
);
    localparam int               IDX_W = $clog2(NUM_STATES);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_STATES - 1);

    typedef enum logic {S_IDLE, S_RUN} fsm_t;

    fsm_t             r_fsm;
    logic [IDX_W-1:0] r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] r_y;
    logic             r_step;
    logic             r_done;
    logic [CNT_W-1:0] r_dwell [NUM_STATES];
    logic [OUT_W-1:0] r_value [NUM_STATES];

    fsm_t             w_fsm_nxt;
    logic [IDX_W-1:0] w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [OUT_W-1:0] w_y_nxt;
    logic             w_step_nxt;
    logic             w_done_nxt;
    logic [CNT_W-1:0] w_dwell_eff;
    logic             w_phase_end;
    logic [IDX_W-1:0] w_state_inc;
    logic             w_cfg_hit;

    // A dwell of 0 behaves as 1; the compare reads the live table so shrinking ends a phase early.
    assign w_dwell_eff = (r_dwell[r_state] == '0) ? CNT_W'(1) : r_dwell[r_state];
    assign w_phase_end = (r_cnt >= (w_dwell_eff - CNT_W'(1)));
    assign w_state_inc = (r_state == LAST) ? '0 : (r_state + IDX_W'(1));
    assign w_cfg_hit   = sq.cfg_we && (int'(sq.cfg_idx) < NUM_STATES);

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_y_nxt     = r_y;
        w_step_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                w_state_nxt = '0;
                w_cnt_nxt   = '0;
                w_y_nxt     = IDLE_VALUE;
                if (sq.start && !sq.stop) begin
                    w_fsm_nxt = S_RUN;
                    w_y_nxt   = r_value[0];
                end
            end
            S_RUN: begin
                if (sq.stop) begin
                    w_fsm_nxt   = S_IDLE;
                    w_state_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_y_nxt     = IDLE_VALUE;
                end else if (!w_phase_end) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    // Re-reading the table lets a value write to the active phase reach y.
                    w_y_nxt   = r_value[r_state];
                end else if (r_state != LAST || sq.loop_en) begin
                    w_state_nxt = w_state_inc;
                    w_cnt_nxt   = '0;
                    w_y_nxt     = r_value[w_state_inc];
                    w_step_nxt  = 1'b1;
                end else begin
                    w_fsm_nxt   = S_IDLE;
                    w_state_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_y_nxt     = IDLE_VALUE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_fsm_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= S_IDLE;
            r_state <= '0;
            r_cnt   <= '0;
            r_y     <= IDLE_VALUE;
            r_step  <= 1'b0;
            r_done  <= 1'b0;
            for (int k = 0; k < NUM_STATES; k++) begin
                r_dwell[k] <= DEF_DWELL;
                r_value[k] <= OUT_W'(k);
            end
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_y     <= w_y_nxt;
            r_step  <= w_step_nxt;
            r_done  <= w_done_nxt;
            if (w_cfg_hit) begin
                r_dwell[sq.cfg_idx] <= sq.cfg_dwell;
                r_value[sq.cfg_idx] <= sq.cfg_value;
            end
        end
    end

    assign sq.y         = r_y;
    assign sq.state     = r_state;
    assign sq.busy      = (r_fsm == S_RUN);
    assign sq.dwell_cnt = r_cnt;
    assign sq.step      = r_step;
    assign sq.done      = r_done;
endmodule

// File: tb/tb_timed_phase_sequencer.sv
// Bench for timed_phase_sequencer: directed vector table, a looping-run sequence,
// then random traffic against a phase/elapsed-time reference model.
module tb_timed_phase_sequencer;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    timed_phase_sequencer_if #(.NUM_STATES(NS), .OUT_W(4), .CNT_W(4)) sq ();

    timed_phase_sequencer #(
        .NUM_STATES(NS), .OUT_W(4), .CNT_W(4), .IDLE_VALUE(4'd0), .DEF_DWELL(4'd1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .sq  (sq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic r, s, p, l, w;
        int   idx, dwell, value;
        int   y, st, busy, cnt, stp, dn;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic r, s, p, l, w, input int idx, dwell, value,
                               input int y, st, busy, cnt, stp, dn);
        vec_t t;
        t.r = r; t.s = s; t.p = p; t.l = l; t.w = w;
        t.idx = idx; t.dwell = dwell; t.value = value;
        t.y = y; t.st = st; t.busy = busy; t.cnt = cnt; t.stp = stp; t.dn = dn;
        return t;
    endfunction

    task automatic set_in(input logic r, s, p, l, w, input int idx, dwell, value);
        rst          = r;
        sq.start     = s;
        sq.stop      = p;
        sq.loop_en   = l;
        sq.cfg_we    = w;
        sq.cfg_idx   = 2'(idx);
        sq.cfg_dwell = 4'(dwell);
        sq.cfg_value = 4'(value);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int y, st, busy, cnt, stp, dn);
        check({tag, ".y"},     int'(sq.y),         y);
        check({tag, ".state"}, int'(sq.state),     st);
        check({tag, ".busy"},  int'(sq.busy),      busy);
        check({tag, ".cnt"},   int'(sq.dwell_cnt), cnt);
        check({tag, ".step"},  int'(sq.step),      stp);
        check({tag, ".done"},  int'(sq.done),      dn);
    endtask

    // Reference model: a run is "which phase, how long in it"; a phase of dwell D
    // occupies D cycles, y shows the table entry as it stood one edge earlier.
    int m_busy, m_ph, m_el, m_y, m_step, m_done;
    int m_dw[NS];
    int m_val[NS];

    function automatic void model_edge();
        int d;
        if (rst) begin
            m_busy = 0; m_ph = 0; m_el = 0; m_y = 0; m_step = 0; m_done = 0;
            for (int k = 0; k < NS; k++) begin
                m_dw[k] = 1;
                m_val[k] = k;
            end
            return;
        end
        m_step = 0;
        m_done = 0;
        if (m_busy == 0) begin
            if (sq.start && !sq.stop) begin
                m_busy = 1;
                m_y = m_val[0];
            end
        end else if (sq.stop) begin
            m_busy = 0; m_ph = 0; m_el = 0; m_y = 0;
        end else begin
            d = (m_dw[m_ph] < 1) ? 1 : m_dw[m_ph];
            if (m_el + 1 < d) begin
                m_el++;
                m_y = m_val[m_ph];
            end else if (m_ph + 1 < NS || sq.loop_en) begin
                m_ph = (m_ph + 1) % NS;
                m_el = 0;
                m_y = m_val[m_ph];
                m_step = 1;
            end else begin
                m_busy = 0; m_ph = 0; m_el = 0; m_y = 0; m_done = 1;
            end
        end
        if (sq.cfg_we && int'(sq.cfg_idx) < NS) begin
            m_dw[sq.cfg_idx] = int'(sq.cfg_dwell);
            m_val[sq.cfg_idx] = int'(sq.cfg_value);
        end
    endfunction

    int ypat[10] = '{1, 1, 5, 5, 5, 8, 11, 11, 11, 11};
    int cfg_d[4] = '{2, 3, 1, 4};
    int cfg_v[4] = '{1, 5, 8, 11};

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);

        //        r s p l w idx d  v    y st b cnt stp dn
        vq.push_back(v(1,0,0,0,0, 0, 0, 0,   0, 0,0,0,0,0));
        vq.push_back(v(0,0,0,0,1, 0, 2, 1,   0, 0,0,0,0,0));
        vq.push_back(v(0,0,0,0,1, 1, 3, 5,   0, 0,0,0,0,0));
        vq.push_back(v(0,0,0,0,1, 2, 1, 8,   0, 0,0,0,0,0));
        vq.push_back(v(0,0,0,0,1, 3, 4,11,   0, 0,0,0,0,0));
        vq.push_back(v(0,1,0,0,0, 0, 0, 0,   1, 0,1,0,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   1, 0,1,1,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   5, 1,1,0,1,0));
        vq.push_back(v(0,1,0,0,0, 0, 0, 0,   5, 1,1,1,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   5, 1,1,2,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   8, 2,1,0,1,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,  11, 3,1,0,1,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,  11, 3,1,1,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,  11, 3,1,2,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,  11, 3,1,3,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   0, 0,0,0,0,1));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   0, 0,0,0,0,0));
        // stop in phase 1, then start+stop while idle
        vq.push_back(v(0,1,0,0,0, 0, 0, 0,   1, 0,1,0,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   1, 0,1,1,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   5, 1,1,0,1,0));
        vq.push_back(v(0,1,0,0,0, 0, 0, 0,   5, 1,1,1,0,0));
        vq.push_back(v(0,0,1,0,0, 0, 0, 0,   0, 0,0,0,0,0));
        vq.push_back(v(0,1,1,0,0, 0, 0, 0,   0, 0,0,0,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   0, 0,0,0,0,0));
        // dwell[2]=0 lasts one cycle; dwell[1] shrunk 3->1 at dwell_cnt=0
        vq.push_back(v(0,0,0,0,1, 2, 0, 8,   0, 0,0,0,0,0));
        vq.push_back(v(0,1,0,0,0, 0, 0, 0,   1, 0,1,0,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   1, 0,1,1,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   5, 1,1,0,1,0));
        vq.push_back(v(0,0,0,0,1, 1, 1, 5,   5, 1,1,1,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   8, 2,1,0,1,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,  11, 3,1,0,1,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,  11, 3,1,1,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,  11, 3,1,2,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,  11, 3,1,3,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   0, 0,0,0,0,1));
        vq.push_back(v(0,0,0,0,1, 1, 3, 5,   0, 0,0,0,0,0));
        vq.push_back(v(0,0,0,0,1, 2, 1, 8,   0, 0,0,0,0,0));
        // value write to active phase 0 reaches y one cycle after the write edge
        vq.push_back(v(0,0,0,0,1, 0, 4, 1,   0, 0,0,0,0,0));
        vq.push_back(v(0,1,0,0,0, 0, 0, 0,   1, 0,1,0,0,0));
        vq.push_back(v(0,0,0,0,1, 0, 4, 9,   1, 0,1,1,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   9, 0,1,2,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   9, 0,1,3,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   5, 1,1,0,1,0));
        vq.push_back(v(0,0,1,0,0, 0, 0, 0,   0, 0,0,0,0,0));
        vq.push_back(v(0,0,0,0,1, 0, 2, 1,   0, 0,0,0,0,0));
        // reset mid-run in phase 3, then a run on the default table
        vq.push_back(v(0,1,0,0,0, 0, 0, 0,   1, 0,1,0,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   1, 0,1,1,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   5, 1,1,0,1,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   5, 1,1,1,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   5, 1,1,2,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   8, 2,1,0,1,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,  11, 3,1,0,1,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,  11, 3,1,1,0,0));
        vq.push_back(v(1,0,0,0,0, 0, 0, 0,   0, 0,0,0,0,0));
        vq.push_back(v(0,1,0,0,0, 0, 0, 0,   0, 0,1,0,0,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   1, 1,1,0,1,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   2, 2,1,0,1,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   3, 3,1,0,1,0));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   0, 0,0,0,0,1));
        vq.push_back(v(0,0,0,0,0, 0, 0, 0,   0, 0,0,0,0,0));

        for (int i = 0; i < vq.size(); i++) begin
            set_in(vq[i].r, vq[i].s, vq[i].p, vq[i].l, vq[i].w, vq[i].idx, vq[i].dwell, vq[i].value);
            tick();
            check_all($sformatf("vec%0d", i), vq[i].y, vq[i].st, vq[i].busy, vq[i].cnt, vq[i].stp, vq[i].dn);
        end

        // Looping run: wrap after 10 cycles, drop loop_en in the second pass.
        for (int k = 0; k < 4; k++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, k, cfg_d[k], cfg_v[k]);
            tick();
        end
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            tick();
            sq.start = 1'b0;
            check($sformatf("loop1[%0d].y", c), int'(sq.y), ypat[c]);
            check($sformatf("loop1[%0d].step", c), int'(sq.step), (c == 2 || c == 5 || c == 6) ? 1 : 0);
        end
        tick();
        check("wrap.y", int'(sq.y), 1);
        check("wrap.step", int'(sq.step), 1);
        check("wrap.done", int'(sq.done), 0);
        check("wrap.busy", int'(sq.busy), 1);
        sq.loop_en = 1'b0;
        for (int c = 1; c < 10; c++) begin
            tick();
            check($sformatf("loop2[%0d].y", c), int'(sq.y), ypat[c]);
            check($sformatf("loop2[%0d].done", c), int'(sq.done), 0);
        end
        tick();
        check("loop2.end.done", int'(sq.done), 1);
        check("loop2.end.busy", int'(sq.busy), 0);
        check("loop2.end.y", int'(sq.y), 0);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rst          = (c == 0) || ($urandom_range(0, 299) == 0);
            sq.start     = ($urandom_range(0, 3) == 0);
            sq.stop      = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 15) == 0) sq.loop_en = ~sq.loop_en;
            sq.cfg_we    = ($urandom_range(0, 5) == 0);
            sq.cfg_idx   = 2'($urandom_range(0, 3));
            sq.cfg_dwell = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
            sq.cfg_value = 4'($urandom);
            model_edge();
            tick();
            check_all($sformatf("rnd%0d", c), m_y, m_ph, m_busy, m_el, m_step, m_done);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
